// File: rtl/qdec_4bit.sv
// qdec_4bit: quadrature decoder with input synchronizers, a run-length glitch
// filter, an init phase that adopts the first accepted level silently, and a
// wrapping 4-bit position counter with a sticky illegal-transition flag.
module qdec_4bit #(
  parameter int SYNC_STAGES = 2,  // 2..3
  parameter int FILT_LEN    = 3   // 1..15
) (
  input  logic       clk,
  input  logic       rst,      // asynchronous, active-low
  input  logic       en,
  input  logic       clr,
  input  logic       a_in,
  input  logic       b_in,
  output logic       step,
  output logic       up_down,
  output logic [3:0] count,
  output logic       err
);

  // Successor of a phase in the forward (up) direction: 00->10->11->01->00.
  function automatic logic [1:0] fwd_next(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_a_sync;
  logic [SYNC_STAGES-1:0] r_b_sync;
  logic [1:0]             w_pair;

  // Shift a_in/b_in through SYNC_STAGES flops each before any other use.
  // NOTE: state is updated with <= so every flop samples pre-edge values;
  // blocking assignments here would collapse the chain into a single stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a_sync <= '0;
      r_b_sync <= '0;
    end else begin
      r_a_sync <= {r_a_sync[SYNC_STAGES-2:0], a_in};
      r_b_sync <= {r_b_sync[SYNC_STAGES-2:0], b_in};
    end
  end

  assign w_pair = {r_a_sync[SYNC_STAGES-1], r_b_sync[SYNC_STAGES-1]};

  // ---------------------------------------------------------------------------
  // Warm-up: the chain outputs reset zeros, not real input, for SYNC_STAGES
  // edges after release. Filtering those zeros during init would adopt a
  // false 00 and then flag a held 11 as an illegal jump.
  // ---------------------------------------------------------------------------
  logic [1:0] r_warm;
  logic       w_warm_done;

  assign w_warm_done = (r_warm == 2'(SYNC_STAGES));

  // Count edges since reset release until the synchronizer holds live data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_warm <= '0;
    end else if (!w_warm_done) begin
      r_warm <= r_warm + 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Glitch filter and accepted state
  // ---------------------------------------------------------------------------
  logic [1:0] r_acc;        // accepted {A,B}
  logic [1:0] r_cand;       // value of the current run
  logic [3:0] r_run;        // length of the current run, 0 = no run
  logic       r_init_pend;  // first acceptance still to come
  logic       w_differs;
  logic [3:0] w_run_nxt;
  logic       w_accept;

  // Run-length of the synchronized pair differing from the accepted state.
  // While init is pending nothing is accepted yet, so any level counts.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_differs = r_init_pend || (w_pair != r_acc);
    w_run_nxt = 4'd0;
    if (w_warm_done && w_differs) begin
      if ((r_run != 4'd0) && (w_pair == r_cand)) begin
        w_run_nxt = r_run + 4'd1;
      end else begin
        w_run_nxt = 4'd1;
      end
    end
    w_accept = (w_run_nxt == 4'(FILT_LEN));
  end

  logic       r_evt;   // an accepted non-init change awaits decoding
  logic [1:0] r_prev;  // accepted state before that change

  // Track the run, commit the accepted state and flag the change for decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cand      <= '0;
      r_run       <= '0;
      r_acc       <= '0;
      r_init_pend <= 1'b1;
      r_evt       <= 1'b0;
      r_prev      <= '0;
    end else begin
      r_cand <= w_pair;
      r_run  <= w_accept ? 4'd0 : w_run_nxt;
      r_evt  <= w_accept && !r_init_pend;
      r_prev <= r_acc;
      if (w_accept) begin
        r_acc       <= w_pair;
        r_init_pend <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transition decode and outputs (one edge after the accepted-state update)
  // ---------------------------------------------------------------------------
  logic w_fwd;
  logic w_rev;
  logic w_illegal;
  logic w_step_ok;
  logic w_err_set;

  // Classify the last accepted change and gate it with en.
  always_comb begin
    w_fwd     = (r_acc == fwd_next(r_prev));
    w_rev     = (r_prev == fwd_next(r_acc));
    w_illegal = ((r_prev ^ r_acc) == 2'b11);
    w_step_ok = r_evt && en && (w_fwd || w_rev);
    w_err_set = r_evt && en && w_illegal;
  end

  // Register step/direction; clr overrides counting and error capture only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step    <= 1'b0;
      up_down <= 1'b1;
      count   <= '0;
      err     <= 1'b0;
    end else begin
      step <= w_step_ok;
      if (w_step_ok) begin
        up_down <= w_fwd;
      end
      if (clr) begin
        count <= '0;
        err   <= 1'b0;
      end else begin
        if (w_step_ok) begin
          count <= w_fwd ? count + 4'd1 : count - 4'd1;
        end
        if (w_err_set) begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/qdec_4bit.md
QDEC_4BIT -- requirements
Module: qdec_4bit

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of input synchronizer flops on a_in/b_in (legal values 2..3).
REQ-002 The block SHALL have parameter FILT_LEN, default 3, giving the consecutive stable samples required to accept a new input level (legal values 1..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port en, input, 1 bit: 1 allows steps, count updates and error capture.
REQ-006 The block SHALL have port clr, input, 1 bit: synchronous clear of count and err.
REQ-007 The block SHALL have port a_in, input, 1 bit: quadrature channel A, asynchronous to clk.
REQ-008 The block SHALL have port b_in, input, 1 bit: quadrature channel B, asynchronous to clk.
REQ-009 The block SHALL have port step, output, 1 bit: one-cycle pulse per legal quadrature transition.
REQ-010 The block SHALL have port up_down, output, 1 bit: direction of the last step, 1 = increment, 0 = decrement.
REQ-011 The block SHALL have port count, output, 4 bits: wrapping position counter.
REQ-012 The block SHALL have port err, output, 1 bit: sticky flag for an illegal transition.

Function
REQ-013 a_in and b_in SHALL each pass through a SYNC_STAGES-deep flop chain before any other use.
REQ-014 The glitch filter SHALL update the accepted state {A,B} on the edge where the synchronized pair has differed from the accepted state, with the same value, for FILT_LEN consecutive edges.
- A change of value restarts the run.
- Runs shorter than FILT_LEN SHALL be ignored.
REQ-015 The first filter acceptance after reset SHALL load the accepted state only: no step, no err, count unchanged (init phase).
REQ-016 The forward sequence SHALL be {A,B} = 00->10->11->01->00; each such transition is an up step.
REQ-017 The reverse sequence SHALL be 00->01->11->10->00; each such transition is a down step.
REQ-018 A transition in which both bits change (00<->11, 10<->01) SHALL be illegal.
- Set err when en=1; no step, count unchanged.
- The accepted state still updates.
REQ-019 step, up_down and count SHALL be registered one edge after the accepted-state update.
- Latency from the first edge sampling a new stable input level to step high = SYNC_STAGES+FILT_LEN+1 edges (6 with defaults).
REQ-020 On an up step, count SHALL increment modulo 16 (15->0), and on a down step it SHALL decrement modulo 16 (0->15).
REQ-021 up_down SHALL update only on a legal step and hold its value otherwise.
REQ-022 When en=0, sync, filter and accepted state SHALL keep running, while step stays 0 and count and err hold.
REQ-023 clr=1 SHALL set count=0 and err=0 on the next edge and take priority over a simultaneous step.
- step still pulses and up_down still updates.
- A simultaneous illegal transition SHALL NOT set err.
REQ-024 The maximum step rate SHALL be one per FILT_LEN cycles; faster input is outside specification and may be filtered away.

Reset
REQ-025 rst=0 SHALL asynchronously force step=0, up_down=1, count=0, err=0, sync and filter state to 0, and the init phase pending.
REQ-026 Assertion of rst mid-filter-run or mid-step SHALL discard all in-flight state, with no pulse on the first edge after release.

Verification
REQ-027 Reset with inputs 00, en=1, then 8 forward transitions -> 8 step pulses, up_down=1, count 0->8, err=0, each step 6 edges after its input change.
REQ-028 count=1, then 3 reverse transitions -> count 1->0->15->14, up_down=0.
REQ-029 A 2-cycle glitch on a_in (FILT_LEN=3) -> no step, count and err unchanged. A 3-cycle stable level -> one step.
REQ-030 Accepted state 00, then a_in and b_in both rise together -> err=1 (sticky), no step. The next legal transition steps normally. clr -> err=0.
REQ-031 Inputs held at 11 through reset release -> init load, no err, no step. A following 11->01 transition -> one up step.
REQ-032 en=0 across 4 forward transitions, then en=1 and 1 forward transition -> count advances by exactly 1. clr coincident with a step -> count=0 and step pulses.
